// File: rtl/score_tracker.sv
// score_tracker: follows the game controller's score on the 100 ms tick.
// It converts the binary score to packed BCD one small step per tick,
// keeps the session best score, and runs the IDLE/PLAY/OVER phase FSM.
// It also drives a blink enable that flashes a new record after game over.
// Every output comes straight from a register.
// The phase output doubles as the FSM state for debug.
module score_tracker #(
  parameter int BLINK_TICKS = 5,  // ticks per blink half-period
  parameter int STEP_MAX    = 2   // BCD units added per tick while catching up (1..9)
) (
  input  logic        clk_100ms,
  input  logic        rst,
  input  logic [15:0] score,
  input  logic [1:0]  status,
  input  logic        game_over,
  output logic [15:0] cur_bcd,
  output logic [15:0] best_bcd,
  output logic [15:0] best_bin,
  output logic        new_record,
  output logic        blink,
  output logic [1:0]  phase,
  output logic        busy
);

  localparam int               CNT_W     = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLINK_TICKS - 1);
  localparam logic [15:0]      STEP_CAP  = 16'(STEP_MAX);
  localparam logic [16:0]      BIN_LIMIT = 17'd9999;
  localparam logic [15:0]      BIN_SAT   = 16'd9999;
  localparam logic [15:0]      BCD_SAT   = 16'h9999;

  typedef enum logic [1:0] {
    PH_IDLE = 2'b00,
    PH_PLAY = 2'b01,
    PH_OVER = 2'b10
  } phase_t;

  phase_t r_phase;
  phase_t w_phase_next;

  logic [15:0]      r_score_prev;
  logic [15:0]      r_pending;
  logic [15:0]      r_cur_bin;
  logic [15:0]      r_cur_bcd;
  logic [15:0]      r_best_bin;
  logic [15:0]      r_best_bcd;
  logic             r_new_record;
  logic             r_busy;
  logic             r_blink;
  logic [CNT_W-1:0] r_blink_cnt;

  logic        w_restart;
  logic        w_sample;
  logic        w_score_up;
  logic        w_score_down;
  logic [15:0] w_delta;
  logic [16:0] w_pend_sum;
  logic [15:0] w_pend_eff;
  logic [15:0] w_base_bin;
  logic [15:0] w_base_bcd;
  logic [15:0] w_step;
  logic [16:0] w_bin_sum;
  logic [15:0] w_bcd_sum;
  logic        w_sat;
  logic [15:0] w_cur_bin_next;
  logic [15:0] w_cur_bcd_next;
  logic [15:0] w_pending_next;
  logic        w_best_beaten;
  logic        w_flash;

  // Add a single BCD digit value (0..9) into a 4-digit packed BCD number.
  // The carry ripples digit by digit. A carry out of the top digit is
  // dropped, because the binary limit check catches that case first.
  function automatic logic [15:0] bcd_add_small(input logic [15:0] bcd_in,
                                                input logic [3:0]  addend);
    logic [15:0] res;
    logic [4:0]  dsum;
    logic [3:0]  cin;
    res = bcd_in;
    cin = addend;
    for (int i = 0; i < 4; i++) begin
      dsum = {1'b0, bcd_in[4*i +: 4]} + {1'b0, cin};
      if (dsum > 5'd9) begin
        res[4*i +: 4] = 4'(dsum - 5'd10);
        cin           = 4'd1;
      end else begin
        res[4*i +: 4] = dsum[3:0];
        cin           = 4'd0;
      end
    end
    return res;
  endfunction

  // Status 01 and 10 mark a restart tick. Scores are only sampled once a game is live.
  assign w_restart = (status == 2'b01) || (status == 2'b10);
  assign w_sample  = (r_phase == PH_PLAY) || (r_phase == PH_OVER);
  assign w_flash   = (r_phase == PH_OVER) && r_new_record;

  // Work out the backlog, this tick's step, and the next display values.
  always_comb begin
    w_score_up   = score > r_score_prev;
    w_score_down = score < r_score_prev;
    w_delta      = score - r_score_prev;
    w_pend_sum   = {1'b0, r_pending} + {1'b0, w_delta};
    w_pend_eff   = r_pending;
    w_base_bin   = r_cur_bin;
    w_base_bcd   = r_cur_bcd;
    if (w_score_up) begin
      w_pend_eff = w_pend_sum[16] ? 16'hFFFF : w_pend_sum[15:0];
    end else if (w_score_down) begin
      // A falling score means a new count started upstream.
      // Rebuild the display from zero.
      w_pend_eff = score;
      w_base_bin = 16'd0;
      w_base_bcd = 16'd0;
    end
    w_step    = (w_pend_eff < STEP_CAP) ? w_pend_eff : STEP_CAP;
    w_bin_sum = {1'b0, w_base_bin} + {1'b0, w_step};
    w_bcd_sum = bcd_add_small(w_base_bcd, w_step[3:0]);
    w_sat     = w_bin_sum > BIN_LIMIT;
    if (w_sat) begin
      // Pin at 9999 and drop the backlog.
      // Later increments re-enter this branch, so the display stays put until restart.
      w_cur_bin_next = BIN_SAT;
      w_cur_bcd_next = BCD_SAT;
      w_pending_next = 16'd0;
    end else begin
      w_cur_bin_next = w_bin_sum[15:0];
      w_cur_bcd_next = w_bcd_sum;
      w_pending_next = w_pend_eff - w_step;
    end
    w_best_beaten = w_cur_bin_next > r_best_bin;
  end

  // Phase FSM next state. A restart overrides every other event.
  always_comb begin
    w_phase_next = r_phase;
    if (w_restart) begin
      w_phase_next = PH_IDLE;
    end else begin
      case (r_phase)
        PH_IDLE: w_phase_next = PH_PLAY;
        PH_PLAY: if (game_over) w_phase_next = PH_OVER;
        PH_OVER: w_phase_next = PH_OVER;
        default: w_phase_next = PH_IDLE;
      endcase
    end
  end

  // Phase FSM state register.
  always_ff @(posedge clk_100ms or negedge rst) begin
    if (!rst) begin
      r_phase <= PH_IDLE;
    end else begin
      r_phase <= w_phase_next;
    end
  end

  // Score datapath: sampling, catch-up step, and best-score tracking.
  always_ff @(posedge clk_100ms or negedge rst) begin
    if (!rst) begin
      r_score_prev <= 16'd0;
      r_pending    <= 16'd0;
      r_cur_bin    <= 16'd0;
      r_cur_bcd    <= 16'd0;
      r_best_bin   <= 16'd0;
      r_best_bcd   <= 16'd0;
      r_new_record <= 1'b0;
      r_busy       <= 1'b0;
    end else if (w_restart) begin
      r_score_prev <= 16'd0;
      r_pending    <= 16'd0;
      r_cur_bin    <= 16'd0;
      r_cur_bcd    <= 16'd0;
      r_new_record <= 1'b0;
      r_busy       <= 1'b0;
    end else if (w_sample) begin
      r_score_prev <= score;
      r_pending    <= w_pending_next;
      r_cur_bin    <= w_cur_bin_next;
      r_cur_bcd    <= w_cur_bcd_next;
      r_busy       <= (w_pending_next != 16'd0);
      if (w_best_beaten) begin
        r_best_bin   <= w_cur_bin_next;
        r_best_bcd   <= w_cur_bcd_next;
        r_new_record <= 1'b1;
      end
    end
  end

  // Record flash: toggle blink each time the half-period counter wraps.
  // Outside the flash, the display is held steady.
  always_ff @(posedge clk_100ms or negedge rst) begin
    if (!rst) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (!w_restart && w_flash) begin
      if (r_blink_cnt == CNT_LAST) begin
        r_blink_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end else begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end
  end

  assign cur_bcd    = r_cur_bcd;
  assign best_bcd   = r_best_bcd;
  assign best_bin   = r_best_bin;
  assign new_record = r_new_record;
  assign blink      = r_blink;
  assign phase      = r_phase;
  assign busy       = r_busy;

endmodule

// File: tb/tb_score_tracker.sv
// tb_score_tracker: directed game scenarios followed by randomized play.
// Every tick is checked against a score-level reference model.
module tb_score_tracker;

  localparam int BLINK_TICKS = 5;
  localparam int STEP_MAX    = 2;
  localparam int EW          = 53;

  logic        clk_100ms = 1'b0;
  logic        rst       = 1'b0;
  logic [15:0] score     = 16'd0;
  logic [1:0]  status    = 2'b01;
  logic        game_over = 1'b0;
  logic [15:0] cur_bcd;
  logic [15:0] best_bcd;
  logic [15:0] best_bin;
  logic        new_record;
  logic        blink;
  logic [1:0]  phase;
  logic        busy;

  score_tracker #(.BLINK_TICKS(BLINK_TICKS), .STEP_MAX(STEP_MAX)) dut (
    .clk_100ms (clk_100ms),
    .rst       (rst),
    .score     (score),
    .status    (status),
    .game_over (game_over),
    .cur_bcd   (cur_bcd),
    .best_bcd  (best_bcd),
    .best_bin  (best_bin),
    .new_record(new_record),
    .blink     (blink),
    .phase     (phase),
    .busy      (busy)
  );

  // clock / watchdog
  always #5 clk_100ms = ~clk_100ms;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model, kept as plain integers at score level.
  int m_phase;  // 0 idle, 1 play, 2 over
  int m_prev;
  int m_pend;
  int m_cur;
  int m_best;
  int m_flash;  // consecutive ticks spent flashing a record
  bit m_nr;
  bit m_busy;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [EW-1:0] model_pack();
    logic bl;
    bl = ((m_flash / BLINK_TICKS) % 2) == 0;
    return {to_bcd(m_cur), to_bcd(m_best), 16'(m_best), m_nr, bl, 2'(m_phase), m_busy};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_prev = 0; m_pend = 0; m_cur = 0; m_best = 0;
    m_flash = 0; m_nr = 1'b0; m_busy = 1'b0;
    exp_q.delete();
  endtask

  // One game tick of the reference model, using the inputs currently applied.
  task automatic model_step();
    int  sc;
    int  pend_eff;
    int  base;
    int  stp;
    bit  restart;
    sc      = int'(score);
    restart = (status == 2'b01) || (status == 2'b10);
    if (restart) begin
      m_phase = 0; m_cur = 0; m_prev = 0; m_pend = 0;
      m_nr = 1'b0; m_busy = 1'b0; m_flash = 0;
    end else begin
      if (m_phase == 2 && m_nr) m_flash++;
      else m_flash = 0;
      if (m_phase != 0) begin
        base     = m_cur;
        pend_eff = m_pend;
        if (sc > m_prev) begin
          pend_eff = m_pend + (sc - m_prev);
          if (pend_eff > 65535) pend_eff = 65535;
        end else if (sc < m_prev) begin
          base     = 0;
          pend_eff = sc;
        end
        stp = (pend_eff < STEP_MAX) ? pend_eff : STEP_MAX;
        if (base + stp > 9999) begin
          m_cur  = 9999;
          m_pend = 0;
        end else begin
          m_cur  = base + stp;
          m_pend = pend_eff - stp;
        end
        m_busy = (m_pend != 0);
        m_prev = sc;
        if (m_cur > m_best) begin
          m_best = m_cur;
          m_nr   = 1'b1;
        end
      end
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1 && game_over) m_phase = 2;
    end
    exp_q.push_back(model_pack());
  endtask

  task automatic compare_outputs(input logic [EW-1:0] e);
    check("cur_bcd",    cur_bcd,             e[52:37]);
    check("best_bcd",   best_bcd,            e[36:21]);
    check("best_bin",   best_bin,            e[20:5]);
    check("new_record", {15'd0, new_record}, {15'd0, e[4]});
    check("blink",      {15'd0, blink},      {15'd0, e[3]});
    check("phase",      {14'd0, phase},      {14'd0, e[2:1]});
    check("busy",       {15'd0, busy},       {15'd0, e[0]});
  endtask

  // driver: advance one tick and score the DUT against the model
  task automatic tick();
    logic [EW-1:0] e;
    model_step();
    @(posedge clk_100ms);
    #1;
    e = exp_q.pop_front();
    compare_outputs(e);
  endtask

  task automatic settle(input int budget);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("settle_busy", {15'd0, busy}, 16'd0);
  endtask

  task automatic new_game();
    status = 2'b01; score = 16'd0; game_over = 1'b0;
    tick();
    status = 2'b00;
    tick();
  endtask

  initial begin
    logic [10:0] blink_pat;
    int          r;

    // reset
    model_reset();
    repeat (3) @(posedge clk_100ms);
    #1;
    compare_outputs(model_pack());
    check("rst_blink", {15'd0, blink}, 16'd1);
    rst = 1'b1;

    // normal play
    status = 2'b01; score = 16'd0;
    tick();
    status = 2'b00;
    tick();
    check("play_phase", {14'd0, phase}, 16'h0001);
    score = 16'd1;
    tick();
    check("play_cur1", cur_bcd, 16'h0001);
    score = 16'd3;
    tick();
    check("play_cur3", cur_bcd, 16'h0003);
    check("play_best3", best_bcd, 16'h0003);
    check("play_nr", {15'd0, new_record}, 16'd1);

    // backlog: jump to 25 in one tick
    new_game();
    score = 16'd25;
    for (int k = 1; k <= 13; k++) begin
      tick();
      check("backlog_cur", cur_bcd, to_bcd((2 * k > 25) ? 25 : 2 * k));
      check("backlog_busy", {15'd0, busy}, 16'(k < 13));
    end

    // digit carries
    new_game();
    score = 16'd9;    tick(); settle(20);
    score = 16'd11;   tick();
    check("carry_11", cur_bcd, 16'h0011);
    score = 16'd99;   tick(); settle(100);
    score = 16'd101;  tick();
    check("carry_101", cur_bcd, 16'h0101);
    score = 16'd999;  tick(); settle(600);
    score = 16'd1001; tick();
    check("carry_1001", cur_bcd, 16'h1001);

    // game over with a record: blink pattern
    game_over = 1'b1;
    blink_pat = 11'b10000011111;
    for (int i = 0; i < 11; i++) begin
      tick();
      check("over_phase", {14'd0, phase}, 16'h0002);
      check("over_blink", {15'd0, blink}, {15'd0, blink_pat[i]});
    end
    game_over = 1'b0;
    tick();
    check("over_hold", {14'd0, phase}, 16'h0002);

    // restart keeps the best score
    status = 2'b01;
    tick();
    check("rs_phase", {14'd0, phase}, 16'h0000);
    check("rs_cur", cur_bcd, 16'h0000);
    check("rs_best", best_bcd, 16'h1001);
    check("rs_best_bin", best_bin, 16'd1001);
    check("rs_nr", {15'd0, new_record}, 16'd0);
    check("rs_blink", {15'd0, blink}, 16'd1);

    // a tie with the best score is not a new record
    status = 2'b00;
    tick();
    score = 16'd1001;
    tick(); settle(600);
    check("tie_cur", cur_bcd, 16'h1001);
    check("tie_nr", {15'd0, new_record}, 16'd0);

    // saturation at 9999
    new_game();
    score = 16'd9998;
    tick(); settle(6000);
    check("sat_pre", cur_bcd, 16'h9998);
    score = 16'd10001;
    tick();
    check("sat_cur", cur_bcd, 16'h9999);
    check("sat_bin", best_bin, 16'd9999);
    check("sat_busy", {15'd0, busy}, 16'd0);
    score = 16'd10003;
    tick();
    check("sat_hold", cur_bcd, 16'h9999);
    check("sat_hold_bin", best_bin, 16'd9999);

    // asynchronous reset in the middle of a catch-up
    new_game();
    score = 16'd12;
    tick();
    check("mid_busy", {15'd0, busy}, 16'd1);
    rst = 1'b0;
    #2;
    model_reset();
    compare_outputs(model_pack());
    check("mid_rst_phase", {14'd0, phase}, 16'h0000);
    check("mid_rst_blink", {15'd0, blink}, 16'd1);
    @(posedge clk_100ms);
    #1;
    rst = 1'b1;

    // randomized play against the model
    for (int t = 0; t < 600; t++) begin
      r = $urandom_range(0, 99);
      if (r < 4) status = 2'($urandom_range(1, 2));
      else       status = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
      if ($urandom_range(0, 19) == 0) game_over = ~game_over;
      r = $urandom_range(0, 99);
      if (r < 70)      score = score + 16'($urandom_range(0, 2));
      else if (r < 85) score = score + 16'($urandom_range(3, 40));
      else if (r < 92) score = 16'($urandom_range(0, int'(score)));
      else if (r < 95) score = 16'($urandom_range(9980, 10010));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
